bcd_cascade_counter: RTL and testbench
======================================

# bcd_cascade_counter

Parametrised N-digit BCD up/down counter: a chain of single-digit BCD stages with ripple-enable carry/borrow, optional synchronous parallel load, and selectable wrap or saturate at the terminal count. It is the generalised successor to the fixed three-digit decade counter and serves timers, event tallies and display drivers that need a configurable digit count. All state is registered on one clock; the terminal-count flag is combinational so counters can be chained.

## Interface
- `DIGITS`, default 3: number of BCD digits; legal range 1..8.
- `WRAP`, default 1: 1 = wrap at terminal count; 0 = saturate at terminal count.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: count enable for the least-significant digit.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `load`  in  1: synchronous parallel load strobe.
- `load_val`  in  4*DIGITS: BCD load value; digit 0 is in bits [3:0].
- `count`  out  4*DIGITS: current BCD value; digit 0 is in bits [3:0].
- `done`  out  1: terminal count reached while enabled (combinational).
- `load_err`  out  1: one-cycle registered pulse after a load that contained a non-BCD digit.

## Operation
- Priority per edge: reset > load > enable > hold.
- Reset: `count` = 0 and `load_err` = 0.
- Digit i advances only when `enable` is 1 and every lower digit is at its terminal value (9 when `up`=1, 0 when `up`=0). Digit 0 advances on `enable` alone.
- Up: a digit goes from 9 to 0 and carries; any other value increments. Down: a digit goes from 0 to 9 and borrows; any other value decrements.
- `done` = `enable` AND all digits at terminal (all 9s when up, all 0s when down). It is combinational, so it can drive the `enable` of a downstream counter.
- With `WRAP`=1, the count wraps all-9s to all-0s (up) and all-0s to all-9s (down).
- With `WRAP`=0, at terminal with `enable` asserted, `count` holds and `done` stays asserted for as long as `enable` is held.
- Load: each digit takes its `load_val` digit. A digit greater than 9 is clamped to 9, and `load_err` pulses high on the following cycle. `load` overrides `enable` in the same cycle, so no count occurs that cycle.
- Changing `up` mid-count takes effect on the next enabled edge; no state is lost.
- Reset asserted mid-count or together with `load` always results in zero.

## Timing
- `count` updates 1 cycle after an enable or load edge. Carry ripple is combinational within the cycle, so all digits update on the same edge.
- `done` has zero latency relative to `count` and `enable`/`up`.
- `load_err` asserts 1 cycle after the load edge and lasts exactly 1 cycle unless the next cycle is also a bad load.
- Critical path: a DIGITS-deep AND chain of terminal detects; this is acceptable up to DIGITS=8.

## Configuration
- `BCD_CASCADE_LOAD_EN` defined: `load`, `load_val` and `load_err` are functional as described above.
- Not defined: the ports remain for pin compatibility. `load` and `load_val` are ignored, `load_err` is tied 0, and no load or clamp logic is generated.

## Structure
- Package `bcd_cnt_pkg`:
  - typedef `bcd_digit_t` (4-bit).
  - constants `BCD_MAX`=9 and `BCD_MIN`=0.
  - function `bcd_clamp` (returns `BCD_MAX` for inputs above 9).
- Sub-module `bcd_digit`: one registered digit with `clk`, `reset`, `en`, `up`, `ld`, `ld_val`, `q` and combinational `term` output. The top instantiates DIGITS copies via a generate loop, chains the `term`/enable AND, and registers `load_err`.

## Test plan
- Reset, then `enable`=1, `up`=1 for 12 cycles (DIGITS=3) -> `count`=012, `done`=0 throughout.
- Load 998, `enable`=1, `up`=1, `WRAP`=1 -> 999 with `done`=1, then 000 on the next edge with `done`=0.
- Load 001, `up`=0, `WRAP`=0 -> 000; further enabled edges hold 000 with `done`=1.
- Load 0x9A5 (middle digit 10) -> `count`=995 and `load_err` high for exactly 1 cycle.
- At 500 with `load`=1 (`load_val`=123) and `enable`=1 on the same edge -> 123, not 124. Assert `reset` together with `load` -> 000.
- Build without `BCD_CASCADE_LOAD_EN`, pulse `load` with 777 -> `count` unchanged and `load_err` stays 0.

Source files
------------

// File: rtl/bcd_cascade_counter_pkg.sv
// Shared types and constants for the BCD cascade counter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: bcd_digit_t (one BCD nibble), BCD_MAX / BCD_MIN terminal values,
// bcd_clamp() which forces any non-decimal nibble to BCD_MAX.
package bcd_cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Non-decimal nibbles (A..F) saturate to 9 so a digit register never
    // holds an illegal BCD code.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_cascade_counter_if.sv
// Control/data bundle between a counter user and bcd_cascade_counter.
// Latency: n/a (wires only).
// Backpressure: none; enable/load are plain strobes, done feeds downstream enables.
//
// master: drives enable, up, load, load_val; observes count, done, load_err.
// slave : the counter itself.
interface bcd_cascade_counter_if #(
    parameter int DIGITS = 3
);
    logic                  enable;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  done;
    logic                  load_err;

    modport master (
        output enable, up, load, load_val,
        input  count, done, load_err
    );

    modport slave (
        input  enable, up, load, load_val,
        output count, done, load_err
    );
endinterface

// File: rtl/bcd_cascade_counter_digit.sv
// One registered BCD digit (0..9) with up/down step, parallel load and terminal detect.
// Latency: q updates 1 cycle after en/ld; term is combinational from q and up.
// Backpressure: none; the digit steps on every edge where en is high.
//
// Ports: clk, reset (sync, active high), en (step enable), up (direction),
//        ld / ld_val (parallel load, ld_val already clamped), q (digit value),
//        term (q is 9 when counting up, 0 when counting down).
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    output bcd_digit_t q,
    output logic       term
);

    assign term = up ? (q == BCD_MAX) : (q == BCD_MIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= BCD_MIN;
        end else if (ld) begin
            q <= ld_val;
        end else if (en) begin
            if (up) begin
                q <= term ? BCD_MIN : q + 4'd1;
            end else begin
                q <= term ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_cascade_counter.sv
// N-digit BCD up/down counter built from a ripple-enable chain of bcd_digit stages.
// Latency: count and load_err update 1 cycle after the edge; done is combinational.
// Backpressure: none; with WRAP=0 the counter holds at terminal while enable stays high.
//
// Ports: clk, reset (sync, active high), bus (slave modport): enable, up, load,
//        load_val, count, done, load_err.
// Build option: define BCD_CASCADE_LOAD_EN to enable parallel load and load_err;
//        otherwise load/load_val are ignored and load_err is tied low.
module bcd_cascade_counter
    import bcd_cnt_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter bit WRAP   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    bcd_cascade_counter_if.slave   bus
);

    // chain[i] = enable AND every digit below i is terminal; chain[DIGITS] is done.
    logic [DIGITS:0]     chain;
    logic [DIGITS-1:0]   term;
    logic                hold;
    logic                ld;
    bcd_digit_t          q      [DIGITS];
    bcd_digit_t          ld_val [DIGITS];
    logic [4*DIGITS-1:0] count_w;

    assign chain[0] = bus.enable;
    assign bus.done = chain[DIGITS];

    // Saturating build: once the whole counter is terminal, freeze every digit.
    assign hold = (WRAP == 1'b0) && chain[DIGITS];

`ifdef BCD_CASCADE_LOAD_EN
    logic [DIGITS-1:0] bad;
    logic              load_err_q;

    assign ld = bus.load;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= bus.load && (|bad);
        end
    end

    assign bus.load_err = load_err_q;
`else
    logic unused_load;

    assign unused_load  = ^{bus.load, bus.load_val};
    assign ld           = 1'b0;
    assign bus.load_err = 1'b0;
`endif

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            assign chain[i+1] = chain[i] & term[i];

`ifdef BCD_CASCADE_LOAD_EN
            assign bad[i]    = bus.load_val[4*i +: 4] > BCD_MAX;
            assign ld_val[i] = bcd_clamp(bus.load_val[4*i +: 4]);
`else
            assign ld_val[i] = BCD_MIN;
`endif

            bcd_digit u_digit (
                .clk    (clk),
                .reset  (reset),
                .en     (chain[i] & ~hold),
                .up     (bus.up),
                .ld     (ld),
                .ld_val (ld_val[i]),
                .q      (q[i]),
                .term   (term[i])
            );
        end
    endgenerate

    always_comb begin
        count_w = '0;
        for (int d = 0; d < DIGITS; d++) begin
            count_w[4*d +: 4] = q[d];
        end
    end

    assign bus.count = count_w;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench: a wrapping and a saturating 3-digit counter share one stimulus
// and are compared against an integer-valued reference model, a vector table and
// hand-written corner sequences.
module tb_bcd_cascade_counter;
    import bcd_cnt_pkg::*;

    localparam int D    = 3;
    localparam int MAXV = 999;
`ifdef BCD_CASCADE_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_cascade_counter_if #(.DIGITS(D)) bus_w ();
    bcd_cascade_counter_if #(.DIGITS(D)) bus_s ();

    assign bus_s.enable   = bus_w.enable;
    assign bus_s.up       = bus_w.up;
    assign bus_s.load     = bus_w.load;
    assign bus_s.load_val = bus_w.load_val;

    bcd_cascade_counter #(.DIGITS(D), .WRAP(1'b1)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    bcd_cascade_counter #(.DIGITS(D), .WRAP(1'b0)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    int   checks = 0;
    int   errors = 0;
    int   m_w    = 0;   // model value of the wrapping counter, plain decimal
    int   m_s    = 0;   // model value of the saturating counter
    logic exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_dec(input logic [11:0] lv);
        int v;
        int p;
        int dg;
        v = 0;
        p = 1;
        for (int k = 0; k < D; k++) begin
            dg = int'(lv[4*k +: 4]);
            if (dg > 9) dg = 9;
            v = v + dg * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic has_bad(input logic [11:0] lv);
        logic b;
        b = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (int'(lv[4*k +: 4]) > 9) b = 1'b1;
        end
        return b;
    endfunction

    function automatic logic model_done(input int v, input logic e, input logic u);
        return e && (u ? (v == MAXV) : (v == 0));
    endfunction

    function automatic int next_val(input int v, input bit wrap, input logic r, input logic e,
                                    input logic u, input logic l, input logic [11:0] lv);
        if (r) return 0;
        if (l && LOAD_EN) return load_dec(lv);
        if (!e) return v;
        if (u) return (v == MAXV) ? (wrap ? 0 : v) : v + 1;
        return (v == 0) ? (wrap ? MAXV : 0) : v - 1;
    endfunction

    // One clock: drive at negedge, check done combinationally, advance model at
    // posedge, then check registered outputs just after the edge.
    task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                         input logic [11:0] lv, output logic done_w, output logic done_s);
        @(negedge clk);
        reset          = r;
        bus_w.enable   = e;
        bus_w.up       = u;
        bus_w.load     = l;
        bus_w.load_val = lv;
        #1;
        done_w = bus_w.done;
        done_s = bus_s.done;
        chk("done_wrap", 32'(bus_w.done), 32'(model_done(m_w, e, u)));
        chk("done_sat",  32'(bus_s.done), 32'(model_done(m_s, e, u)));
        @(posedge clk);
        m_w     = next_val(m_w, 1'b1, r, e, u, l, lv);
        m_s     = next_val(m_s, 1'b0, r, e, u, l, lv);
        exp_err = !r && l && LOAD_EN && has_bad(lv);
        #1;
        chk("count_wrap", 32'(bus_w.count), 32'(to_bcd(m_w)));
        chk("count_sat",  32'(bus_s.count), 32'(to_bcd(m_s)));
        chk("err_wrap",   32'(bus_w.load_err), 32'(exp_err));
        chk("err_sat",    32'(bus_s.load_err), 32'(exp_err));
    endtask

    typedef struct {
        logic        r;
        logic        e;
        logic        u;
        logic        l;
        logic [11:0] lv;
        logic [11:0] exp_cnt;
        logic        exp_done;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic dw;
        logic ds;
        logic [11:0] saved;

        reset          = 1'b1;
        bus_w.enable   = 1'b0;
        bus_w.up       = 1'b1;
        bus_w.load     = 1'b0;
        bus_w.load_val = '0;

        // Vector table: reset, 12 up counts, hold, one down, then a load strobe.
        tbl[0] = '{r:1'b1, e:1'b0, u:1'b1, l:1'b0, lv:12'h000, exp_cnt:12'h000, exp_done:1'b0};
        for (int k = 1; k <= 12; k++) begin
            tbl[k] = '{r:1'b0, e:1'b1, u:1'b1, l:1'b0, lv:12'h000,
                       exp_cnt:{4'd0, 4'(k / 10), 4'(k % 10)}, exp_done:1'b0};
        end
        tbl[13] = '{r:1'b0, e:1'b0, u:1'b1, l:1'b0, lv:12'h000, exp_cnt:12'h012, exp_done:1'b0};
        tbl[14] = '{r:1'b0, e:1'b1, u:1'b0, l:1'b0, lv:12'h000, exp_cnt:12'h011, exp_done:1'b0};
        tbl[15] = '{r:1'b0, e:1'b1, u:1'b1, l:1'b1, lv:12'h777,
                    exp_cnt:(LOAD_EN ? 12'h777 : 12'h012), exp_done:1'b0};

        for (int k = 0; k < 16; k++) begin
            cycle(tbl[k].r, tbl[k].e, tbl[k].u, tbl[k].l, tbl[k].lv, dw, ds);
            chk($sformatf("tbl%0d_cnt_wrap", k), 32'(bus_w.count), 32'(tbl[k].exp_cnt));
            chk($sformatf("tbl%0d_cnt_sat", k),  32'(bus_s.count), 32'(tbl[k].exp_cnt));
            chk($sformatf("tbl%0d_done", k),     32'(dw),          32'(tbl[k].exp_done));
        end

        // Down from 000: wrap goes to 999, saturate holds 000; done high on both.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, dw, ds);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, dw, ds);
        chk("dn0_done_wrap", 32'(dw), 32'd1);
        chk("dn0_done_sat",  32'(ds), 32'd1);
        chk("dn0_cnt_wrap",  32'(bus_w.count), 32'h999);
        chk("dn0_cnt_sat",   32'(bus_s.count), 32'h000);
        // Direction flip: wrap 999 -> 000 with done, saturate 000 -> 001.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, dw, ds);
        chk("up9_done_wrap", 32'(dw), 32'd1);
        chk("up9_done_sat",  32'(ds), 32'd0);
        chk("up9_cnt_wrap",  32'(bus_w.count), 32'h000);
        chk("up9_cnt_sat",   32'(bus_s.count), 32'h001);

`ifdef BCD_CASCADE_LOAD_EN
        // Load 998, count up across the terminal.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h998, dw, ds);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, dw, ds);
        chk("l998_first", 32'(bus_w.count), 32'h999);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, dw, ds);
        chk("l998_done", 32'(dw), 32'd1);
        chk("l998_wrap", 32'(bus_w.count), 32'h000);
        chk("l998_sat",  32'(bus_s.count), 32'h999);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, dw, ds);
        chk("l998_satdone", 32'(ds), 32'd1);
        chk("l998_sathold", 32'(bus_s.count), 32'h999);
        // Load 001, count down to zero and hold in saturate mode.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'h001, dw, ds);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, dw, ds);
        chk("l001_zero", 32'(bus_s.count), 32'h000);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, dw, ds);
            chk("l001_done", 32'(ds), 32'd1);
            chk("l001_hold", 32'(bus_s.count), 32'h000);
        end
        // Non-BCD middle digit: clamp to 995, one-cycle error pulse.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h9A5, dw, ds);
        chk("bad_cnt", 32'(bus_w.count), 32'h995);
        chk("bad_err", 32'(bus_w.load_err), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, dw, ds);
        chk("bad_err_gone", 32'(bus_w.load_err), 32'd0);
        // Load beats enable; reset beats load.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h500, dw, ds);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 12'h123, dw, ds);
        chk("ld_over_en", 32'(bus_w.count), 32'h123);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'hFAF, dw, ds);
        chk("rst_over_ld", 32'(bus_w.count), 32'h000);
        chk("rst_over_ld_err", 32'(bus_w.load_err), 32'd0);
`else
        // Load is inert in this build.
        saved = bus_w.count;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h777, dw, ds);
        chk("noload_cnt", 32'(bus_w.count), 32'(saved));
        chk("noload_err", 32'(bus_w.load_err), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'hAAA, dw, ds);
        chk("noload_err2", 32'(bus_w.load_err), 32'd0);
`endif

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
                  ($urandom_range(7) == 0), 12'($urandom), dw, ds);
        end

        // Long up run from zero: wrap rolls over, saturate parks at 999 with done.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, dw, ds);
        for (int k = 0; k < 1005; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, dw, ds);
        end
        chk("long_wrap", 32'(bus_w.count), 32'h005);
        chk("long_sat",  32'(bus_s.count), 32'h999);
        chk("long_satdone", 32'(ds), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
